// File: rtl/serdes_link_pkg.sv
// -----------------------------------------------------------------------------
// serdes_link_pkg
// Shared constants for the SERDES link: serializer framing constants, the
// word-aligner default parameters and the aligner state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package serdes_link_pkg;

  // Serializer-side constants (word framing shared by both link directions).
  localparam int         SER_WORD_WIDTH   = 8;
  localparam int         SER_DDR_RATIO    = 4;
  localparam logic [7:0] SER_IDLE_WORD    = 8'hBC;

  // Word-aligner defaults.
  localparam logic [7:0] DEF_TRAINING_PATTERN = 8'h5C;
  localparam int         DEF_LOCK_COUNT       = 16;
  localparam int         DEF_SLIP_WAIT        = 3;
  localparam int         DEF_LOSS_COUNT       = 4;

  // Number of bitslips without lock after which align_fail is raised.
  localparam int         ALIGN_FAIL_SLIPS     = 8;

  typedef enum logic [2:0] {
    ST_SEARCH = 3'd0,
    ST_SLIP   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_LOCKED = 3'd4
  } align_state_e;

  // Counter width able to hold 'value' itself (one spare bit).
  function automatic int cnt_width(input int value);
    return $clog2(value) + 1;
  endfunction

endpackage

// File: rtl/pattern_match_counter.sv
// -----------------------------------------------------------------------------
// pattern_match_counter
// Compares a data word against a reference pattern each cycle and keeps a
// saturating run-length count of consecutive events. The event is either a
// match or a mismatch (COUNT_MISMATCH); a non-event clears the run.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   clear    in   synchronous clear of the run counter (highest priority)
//   enable   in   counting enabled this cycle; otherwise the count holds
//   data     in   word under test
//   pattern  in   reference word
//   reached  out  this cycle's event brings the run to THRESHOLD
// -----------------------------------------------------------------------------
module pattern_match_counter
  import serdes_link_pkg::*;
#(
  parameter int WIDTH          = SER_WORD_WIDTH,
  parameter int THRESHOLD      = DEF_LOCK_COUNT,
  parameter bit COUNT_MISMATCH = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] pattern,
  output logic             reached
);

  localparam int               CNT_W    = cnt_width(THRESHOLD);
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_inc_s;
  logic [CNT_W-1:0] count_next_s;
  logic             hit_s;
  logic             event_s;

  // Event detection, saturating increment and next count.
  always_comb begin
    hit_s        = (data == pattern);
    event_s      = COUNT_MISMATCH ? ~hit_s : hit_s;
    count_inc_s  = count_r;
    count_next_s = count_r;
    reached      = 1'b0;

    if (count_r >= THRESH_C) begin
      count_inc_s = THRESH_C;
    end else begin
      count_inc_s = count_r + CNT_W'(1);
    end

    if (clear) begin
      count_next_s = '0;
    end else if (enable) begin
      if (event_s) begin
        count_next_s = count_inc_s;
        reached      = (count_inc_s >= THRESH_C);
      end else begin
        count_next_s = '0;
      end
    end else begin
      count_next_s = count_r;
    end
  end

  // Run-length counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else begin
      count_r <= count_next_s;
    end
  end

endmodule

// File: rtl/deserializer_word_aligner.sv
// -----------------------------------------------------------------------------
// deserializer_word_aligner
// Fabric-side word aligner for an 8-bit deserializer. Hunts for the training
// word by pulsing BITSLIP, confirms it over LOCK_COUNT consecutive words,
// then monitors for loss of lock. The deserializer primitive sits outside.
//
// Ports:
//   slow_clock       in   divided deserializer clock, all logic on rising edge
//   rst_n            in   asynchronous active-low reset
//   parallel_input   in   [7:0] deserialized word, bit 0 received first
//   realign          in   one-cycle request to restart alignment
//   monitor_enable   in   count mismatches toward loss of lock while LOCKED
//   bitslip          out  one-cycle pulse to the deserializer BITSLIP input
//   parallel_output  out  [7:0] parallel_input delayed one cycle
//   output_valid     out  parallel_output carries aligned data
//   aligned          out  block is in LOCKED
//   slip_count       out  [2:0] bitslips since last restart, modulo 8
//   align_fail       out  sticky: eight bitslips issued without locking
// -----------------------------------------------------------------------------
module deserializer_word_aligner
  import serdes_link_pkg::*;
#(
  parameter logic [7:0] TRAINING_PATTERN = DEF_TRAINING_PATTERN,
  parameter int         LOCK_COUNT       = DEF_LOCK_COUNT,
  parameter int         SLIP_WAIT        = DEF_SLIP_WAIT,
  parameter int         LOSS_COUNT       = DEF_LOSS_COUNT
) (
  input  logic       slow_clock,
  input  logic       rst_n,
  input  logic [7:0] parallel_input,
  input  logic       realign,
  input  logic       monitor_enable,
  output logic       bitslip,
  output logic [7:0] parallel_output,
  output logic       output_valid,
  output logic       aligned,
  output logic [2:0] slip_count,
  output logic       align_fail
);

  localparam int                 WAIT_W      = cnt_width(SLIP_WAIT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST_C = WAIT_W'((SLIP_WAIT > 0) ? (SLIP_WAIT - 1) : 0);
  localparam int                 TOTAL_W     = cnt_width(ALIGN_FAIL_SLIPS);
  localparam logic [TOTAL_W-1:0] TOTAL_MAX_C = TOTAL_W'(ALIGN_FAIL_SLIPS);
  localparam logic [TOTAL_W-1:0] FAIL_ARM_C  = TOTAL_W'(ALIGN_FAIL_SLIPS - 1);

  align_state_e        state_r;
  align_state_e        next_state_s;
  logic                match_s;
  logic                lock_en_s;
  logic                lock_clr_s;
  logic                lock_hit_s;
  logic                loss_en_s;
  logic                loss_clr_s;
  logic                loss_hit_s;
  logic                enter_slip_s;
  logic                enter_locked_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [TOTAL_W-1:0]  slip_total_r;
  logic                bitslip_r;
  logic [7:0]          parallel_output_r;
  logic                output_valid_r;
  logic                aligned_r;
  logic [2:0]          slip_count_r;
  logic                align_fail_r;

  // Counter controls: the lock counter runs only while hunting/confirming,
  // the loss counter only while LOCKED with monitoring enabled.
  always_comb begin
    match_s    = (parallel_input == TRAINING_PATTERN);
    lock_en_s  = (state_r == ST_SEARCH) || (state_r == ST_CHECK);
    lock_clr_s = realign || !lock_en_s;
    loss_en_s  = (state_r == ST_LOCKED) && monitor_enable;
    loss_clr_s = realign || !loss_en_s;
  end

  // Consecutive-match counter for SEARCH/CHECK; SEARCH match starts it at 1.
  pattern_match_counter #(
    .WIDTH          (8),
    .THRESHOLD      (LOCK_COUNT),
    .COUNT_MISMATCH (1'b0)
  ) u_lock_counter (
    .clk     (slow_clock),
    .rst_n   (rst_n),
    .clear   (lock_clr_s),
    .enable  (lock_en_s),
    .data    (parallel_input),
    .pattern (TRAINING_PATTERN),
    .reached (lock_hit_s)
  );

  // Consecutive-mismatch counter for loss of lock.
  pattern_match_counter #(
    .WIDTH          (8),
    .THRESHOLD      (LOSS_COUNT),
    .COUNT_MISMATCH (1'b1)
  ) u_loss_counter (
    .clk     (slow_clock),
    .rst_n   (rst_n),
    .clear   (loss_clr_s),
    .enable  (loss_en_s),
    .data    (parallel_input),
    .pattern (TRAINING_PATTERN),
    .reached (loss_hit_s)
  );

  // Next-state logic; realign overrides every other transition.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_SEARCH: begin
        if (match_s) begin
          next_state_s = ST_CHECK;
        end else begin
          next_state_s = ST_SLIP;
        end
      end
      ST_SLIP: begin
        if (SLIP_WAIT > 0) begin
          next_state_s = ST_WAIT;
        end else begin
          next_state_s = ST_SEARCH;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WAIT_LAST_C) begin
          next_state_s = ST_SEARCH;
        end else begin
          next_state_s = ST_WAIT;
        end
      end
      ST_CHECK: begin
        if (!match_s) begin
          next_state_s = ST_SLIP;
        end else if (lock_hit_s) begin
          next_state_s = ST_LOCKED;
        end else begin
          next_state_s = ST_CHECK;
        end
      end
      ST_LOCKED: begin
        if (loss_hit_s) begin
          next_state_s = ST_SEARCH;
        end else begin
          next_state_s = ST_LOCKED;
        end
      end
      default: begin
        next_state_s = ST_SEARCH;
      end
    endcase

    if (realign) begin
      next_state_s = ST_SEARCH;
    end else begin
      next_state_s = next_state_s;
    end

    enter_slip_s   = (next_state_s == ST_SLIP);
    enter_locked_s = (next_state_s == ST_LOCKED);
  end

  // State register.
  always_ff @(posedge slow_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_SEARCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // WAIT dwell counter: restarts on every entry into WAIT.
  always_ff @(posedge slow_clock or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_WAIT) && (next_state_s == ST_WAIT)) begin
      if (wait_cnt_r < WAIT_LAST_C) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Slip bookkeeping: wrapping slip_count plus a saturating total used to
  // arm align_fail; the total restarts on lock so a fail means eight slips
  // in a row without lock.
  always_ff @(posedge slow_clock or negedge rst_n) begin
    if (!rst_n) begin
      slip_count_r <= 3'd0;
      slip_total_r <= '0;
      align_fail_r <= 1'b0;
    end else if (realign) begin
      slip_count_r <= 3'd0;
      slip_total_r <= '0;
      align_fail_r <= 1'b0;
    end else if (enter_locked_s) begin
      slip_count_r <= slip_count_r;
      slip_total_r <= '0;
      align_fail_r <= 1'b0;
    end else if (enter_slip_s) begin
      slip_count_r <= slip_count_r + 3'd1;
      if (slip_total_r < TOTAL_MAX_C) begin
        slip_total_r <= slip_total_r + TOTAL_W'(1);
      end else begin
        slip_total_r <= slip_total_r;
      end
      if (slip_total_r >= FAIL_ARM_C) begin
        align_fail_r <= 1'b1;
      end else begin
        align_fail_r <= align_fail_r;
      end
    end else begin
      slip_count_r <= slip_count_r;
      slip_total_r <= slip_total_r;
      align_fail_r <= align_fail_r;
    end
  end

  // Registered outputs; bitslip is high exactly while the state is SLIP.
  always_ff @(posedge slow_clock or negedge rst_n) begin
    if (!rst_n) begin
      bitslip_r         <= 1'b0;
      parallel_output_r <= 8'h00;
      output_valid_r    <= 1'b0;
      aligned_r         <= 1'b0;
    end else begin
      bitslip_r         <= enter_slip_s;
      parallel_output_r <= parallel_input;
      output_valid_r    <= enter_locked_s;
      aligned_r         <= enter_locked_s;
    end
  end

  assign bitslip         = bitslip_r;
  assign parallel_output = parallel_output_r;
  assign output_valid    = output_valid_r;
  assign aligned         = aligned_r;
  assign slip_count      = slip_count_r;
  assign align_fail      = align_fail_r;

endmodule

// File: tb/tb_deserializer_word_aligner.sv
// -----------------------------------------------------------------------------
// tb_deserializer_word_aligner
// Drives the aligner from a behavioural link model (repeating training word
// seen through a deserializer whose bit offset advances on every bitslip)
// and checks every output cycle against a reference model via a scoreboard.
// -----------------------------------------------------------------------------
module tb_deserializer_word_aligner;

  localparam logic [7:0] PAT       = 8'h5C;
  localparam int         LOCK      = 16;
  localparam int         SLIP_WAIT = 3;
  localparam int         LOSS      = 4;

  logic       slow_clock;
  logic       rst_n;
  logic [7:0] parallel_input;
  logic       realign;
  logic       monitor_enable;
  logic       bitslip;
  logic [7:0] parallel_output;
  logic       output_valid;
  logic       aligned;
  logic [2:0] slip_count;
  logic       align_fail;

  deserializer_word_aligner dut (
    .slow_clock      (slow_clock),
    .rst_n           (rst_n),
    .parallel_input  (parallel_input),
    .realign         (realign),
    .monitor_enable  (monitor_enable),
    .bitslip         (bitslip),
    .parallel_output (parallel_output),
    .output_valid    (output_valid),
    .aligned         (aligned),
    .slip_count      (slip_count),
    .align_fail      (align_fail)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  typedef struct packed {
    logic       bitslip;
    logic [7:0] dout;
    logic       valid;
    logic       aligned;
    logic [2:0] slips;
    logic       fail;
  } exp_t;

  exp_t sb_q[$];
  int   pulse_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Reference model: "ignore" window after a slip, match run, lock flag,
  // miss run while locked, slip bookkeeping.
  int   m_wait_left;
  int   m_run;
  int   m_miss;
  int   m_slip_cnt;
  int   m_total;
  bit   m_locked;
  bit   m_fail;
  bit   m_bitslip;

  // Link model.
  int         ch_off;
  bit         ch_fixed;
  logic [7:0] ch_fixed_val;

  function automatic logic [7:0] rot_word(input logic [7:0] p, input int off);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = p[(i + off) % 8];
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    m_wait_left = 0; m_run = 0; m_miss = 0; m_slip_cnt = 0; m_total = 0;
    m_locked = 1'b0; m_fail = 1'b0; m_bitslip = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] din, input logic re, input logic mon);
    m_bitslip = 1'b0;
    if (re) begin
      model_clear();
    end else if (m_locked) begin
      if (mon && (din != PAT)) begin
        m_miss++;
        if (m_miss >= LOSS) begin
          m_locked = 1'b0; m_miss = 0; m_run = 0;
        end
      end else begin
        m_miss = 0;
      end
    end else if (m_wait_left > 0) begin
      m_wait_left--;
    end else if (din == PAT) begin
      m_run++;
      if (m_run >= LOCK) begin
        m_locked = 1'b1; m_run = 0; m_total = 0; m_fail = 1'b0;
      end
    end else begin
      m_run       = 0;
      m_bitslip   = 1'b1;
      m_slip_cnt  = (m_slip_cnt + 1) % 8;
      m_total++;
      if (m_total >= 8) m_fail = 1'b1;
      m_wait_left = SLIP_WAIT + 1;
    end
  endtask

  // One clock: drive at negedge, model at posedge, sample pulses #1 later.
  task automatic drive_cycle(input logic re, input logic mon, input bit corrupt);
    logic [7:0] din;
    exp_t       e;
    din = ch_fixed ? ch_fixed_val : rot_word(PAT, ch_off);
    if (corrupt) din = din ^ 8'($urandom_range(1, 255));
    @(negedge slow_clock);
    parallel_input = din;
    realign        = re;
    monitor_enable = mon;
    @(posedge slow_clock);
    cyc++;
    model_step(din, re, mon);
    e.bitslip = m_bitslip;
    e.dout    = din;
    e.valid   = m_locked;
    e.aligned = m_locked;
    e.slips   = 3'(m_slip_cnt);
    e.fail    = m_fail;
    sb_q.push_back(e);
    if (m_bitslip) ch_off = (ch_off + 1) % 8;
    #1;
    if (bitslip === 1'b1) pulse_q.push_back(cyc);
  endtask

  task automatic pulse_stats(input int from_idx, output int n, output int min_gap);
    n       = pulse_q.size() - from_idx;
    min_gap = 1000;
    for (int i = from_idx + 1; i < pulse_q.size(); i++)
      if (pulse_q[i] - pulse_q[i-1] < min_gap) min_gap = pulse_q[i] - pulse_q[i-1];
  endtask

  initial begin
    int idx;
    int n;
    int g;

    rst_n = 1'b0; parallel_input = 8'h00; realign = 1'b0; monitor_enable = 1'b0;
    ch_off = 0; ch_fixed = 1'b0; ch_fixed_val = 8'h00;
    model_clear();

    fork
      begin : monitor_p
        exp_t e;
        forever begin
          @(negedge slow_clock);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("bitslip",         32'(bitslip),         32'(e.bitslip));
            check("parallel_output", 32'(parallel_output), 32'(e.dout));
            check("output_valid",    32'(output_valid),    32'(e.valid));
            check("aligned",         32'(aligned),         32'(e.aligned));
            check("slip_count",      32'(slip_count),      32'(e.slips));
            check("align_fail",      32'(align_fail),      32'(e.fail));
          end
        end
      end
    join_none

    // Reset values.
    #1;
    check("rst_bitslip", 32'(bitslip), 32'd0);
    check("rst_pout",    32'(parallel_output), 32'h00);
    check("rst_valid",   32'(output_valid), 32'd0);
    check("rst_aligned", 32'(aligned), 32'd0);
    check("rst_slips",   32'(slip_count), 32'd0);
    check("rst_fail",    32'(align_fail), 32'd0);
    repeat (2) @(posedge slow_clock);
    #2 rst_n = 1'b1;

    // Aligned input from reset: lock after exactly 16 matches, no slips.
    idx = pulse_q.size();
    repeat (15) drive_cycle(1'b0, 1'b1, 1'b0);
    check("lock_15", 32'(aligned), 32'd0);
    drive_cycle(1'b0, 1'b1, 1'b0);
    check("lock_16", 32'(aligned), 32'd1);
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);
    pulse_stats(idx, n, g);
    check("aligned_no_pulses", 32'(n), 32'd0);
    check("aligned_slips", 32'(slip_count), 32'd0);

    // Word rotated by 3 bits: five slips, spaced >= SLIP_WAIT+2, then lock.
    ch_off = 3;
    drive_cycle(1'b1, 1'b1, 1'b0);
    idx = pulse_q.size();
    repeat (45) drive_cycle(1'b0, 1'b1, 1'b0);
    pulse_stats(idx, n, g);
    check("rot3_pulses", 32'(n), 32'd5);
    check("rot3_spacing", 32'(g >= SLIP_WAIT + 2), 32'd1);
    check("rot3_aligned", 32'(aligned), 32'd1);
    check("rot3_slips", 32'(slip_count), 32'd5);

    // Loss of lock: three misses then a match keep lock; four drop it.
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b1);
    drive_cycle(1'b0, 1'b1, 1'b0);
    check("loss3_aligned", 32'(aligned), 32'd1);
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b1);
    check("loss_pre4", 32'(aligned), 32'd1);
    drive_cycle(1'b0, 1'b1, 1'b1);
    check("loss4_aligned", 32'(aligned), 32'd0);
    check("loss4_valid", 32'(output_valid), 32'd0);

    // Relock, then misses with monitoring disabled are ignored.
    repeat (16) drive_cycle(1'b0, 1'b1, 1'b0);
    check("relock", 32'(aligned), 32'd1);
    repeat (6) drive_cycle(1'b0, 1'b0, 1'b1);
    check("mon_off_aligned", 32'(aligned), 32'd1);

    // realign on the 16th match wins over lock.
    drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (15) drive_cycle(1'b0, 1'b1, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0);
    check("realign16_aligned", 32'(aligned), 32'd0);
    check("realign16_slips", 32'(slip_count), 32'd0);
    repeat (16) drive_cycle(1'b0, 1'b1, 1'b0);
    check("realign16_relock", 32'(aligned), 32'd1);

    // Constant 0x00: align_fail on the eighth slip, slip_count wraps, slips go on.
    ch_fixed = 1'b1; ch_fixed_val = 8'h00;
    drive_cycle(1'b1, 1'b1, 1'b0);
    idx = pulse_q.size();
    repeat (35) drive_cycle(1'b0, 1'b1, 1'b0);
    check("fail_before8", 32'(align_fail), 32'd0);
    check("slips_7", 32'(slip_count), 32'd7);
    drive_cycle(1'b0, 1'b1, 1'b0);
    check("fail_at8", 32'(align_fail), 32'd1);
    check("slips_wrap", 32'(slip_count), 32'd0);
    repeat (10) drive_cycle(1'b0, 1'b1, 1'b0);
    pulse_stats(idx, n, g);
    check("zero_pulses", 32'(n), 32'd10);
    check("zero_spacing", 32'(g >= SLIP_WAIT + 2), 32'd1);

    // Reset asserted in WAIT: outputs clear without a clock edge, no slip after.
    drive_cycle(1'b1, 1'b1, 1'b0);
    repeat (3) drive_cycle(1'b0, 1'b1, 1'b0);
    @(negedge slow_clock);
    #1 rst_n = 1'b0;
    #1;
    check("wrst_bitslip", 32'(bitslip), 32'd0);
    check("wrst_pout",    32'(parallel_output), 32'h00);
    check("wrst_valid",   32'(output_valid), 32'd0);
    check("wrst_aligned", 32'(aligned), 32'd0);
    check("wrst_slips",   32'(slip_count), 32'd0);
    check("wrst_fail",    32'(align_fail), 32'd0);
    repeat (3) begin
      @(posedge slow_clock);
      #1;
      check("wrst_hold_bitslip", 32'(bitslip), 32'd0);
    end
    #1 rst_n = 1'b1;
    model_clear();
    repeat (8) drive_cycle(1'b0, 1'b1, 1'b0);

    // Randomized link: random phase, noise, realign and monitor_enable.
    ch_fixed = 1'b0;
    ch_off   = int'($urandom_range(0, 7));
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) ch_off = int'($urandom_range(0, 7));
      drive_cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 15) == 0));
    end

    @(negedge slow_clock);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
